// File: rtl/hough_vote_accumulator.sv
// Hough accumulator engine: clears the bin array, applies votes as saturating
// read-modify-write increments on a slotted single memory port, and scans for the top-K bins.
module hough_vote_accumulator #(
    parameter int ANGLE_BITS  = 6,
    parameter int RADIUS_BITS = 9,
    parameter int COUNT_WIDTH = 16,
    parameter int MEM_LAT     = 2,
    parameter int TOP_K       = 4,
    parameter int ADDR_WIDTH  = 19,
    parameter int DATA_WIDTH  = 36
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               cmd_clear,
    input  logic                               cmd_scan,
    input  logic                               vote_valid,
    output logic                               vote_ready,
    input  logic [ANGLE_BITS-1:0]              vote_angle,
    input  logic [RADIUS_BITS-1:0]             vote_radius,
    output logic [ADDR_WIDTH-1:0]              mem_addr,
    output logic                               mem_we,
    output logic [DATA_WIDTH-1:0]              mem_write_data,
    input  logic [DATA_WIDTH-1:0]              mem_read_data,
    output logic                               busy,
    output logic                               done,
    output logic                               saturated,
    output logic                               peak_valid,
    output logic [TOP_K*ANGLE_BITS-1:0]        peak_angle,
    output logic [TOP_K*RADIUS_BITS-1:0]       peak_radius,
    output logic [TOP_K*COUNT_WIDTH-1:0]       peak_count
);
    localparam int BW = ANGLE_BITS + RADIUS_BITS;
    // Vote token age index: read driven at 1, data back at RI, write driven at WI.
    localparam int RI = 1 + MEM_LAT;
    localparam int WI = 2 + MEM_LAT + (MEM_LAT % 2);
    localparam int HD = WI / 2 + 2;
    localparam logic [COUNT_WIDTH-1:0] CMAX = '1;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_DRAIN, S_SCAN, S_SCAN_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {P_NONE, P_CLEAR, P_SCAN} cmd_t;

    state_t state_q, state_d;
    cmd_t   pend_q, pend_d;
    logic   phase_q, phase_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic   saturated_q, saturated_d;
    logic   peak_valid_q, peak_valid_d;

    logic                   tok_v_q [WI+1];
    logic                   tok_v_d [WI+1];
    logic [BW-1:0]          tok_a_q [WI+1];
    logic [BW-1:0]          tok_a_d [WI+1];
    logic                   hist_v_q [HD];
    logic                   hist_v_d [HD];
    logic [BW-1:0]          hist_a_q [HD];
    logic [BW-1:0]          hist_a_d [HD];
    logic [COUNT_WIDTH-1:0] hist_c_q [HD];
    logic [COUNT_WIDTH-1:0] hist_c_d [HD];
    logic                   scan_v_q [MEM_LAT];
    logic                   scan_v_d [MEM_LAT];
    logic [BW-1:0]          scan_a_q [MEM_LAT];
    logic [BW-1:0]          scan_a_d [MEM_LAT];
    logic [COUNT_WIDTH-1:0] pk_c_q [TOP_K];
    logic [COUNT_WIDTH-1:0] pk_c_d [TOP_K];
    logic [BW-1:0]          pk_a_q [TOP_K];
    logic [BW-1:0]          pk_a_d [TOP_K];

    logic                   accept;
    logic                   early_busy;
    logic [COUNT_WIDTH-1:0] rd_cnt;
    logic [COUNT_WIDTH-1:0] old_cnt;
    logic                   found;
    int unsigned            idx;
    cmd_t                   cmd_new;
    cmd_t                   start;

    generate
        if (DATA_WIDTH > COUNT_WIDTH) begin : g_unused
            logic unused_hi;
            assign unused_hi = ^mem_read_data[DATA_WIDTH-1:COUNT_WIDTH];
        end
    endgenerate

    assign rd_cnt     = mem_read_data[COUNT_WIDTH-1:0];
    assign vote_ready = (state_q == S_IDLE) && !phase_q && (pend_q == P_NONE);
    assign accept     = vote_valid && vote_ready;
    assign done       = (state_q == S_DONE);
    assign saturated  = saturated_q;
    assign peak_valid = peak_valid_q;

    always_comb begin
        busy = (state_q != S_IDLE);
        early_busy = accept;
        for (int unsigned k = 0; k <= WI; k++) begin
            busy = busy || tok_v_q[k];
            if (k < WI) early_busy = early_busy || tok_v_q[k];
        end
    end

    always_comb begin
        mem_addr       = '0;
        mem_we         = 1'b0;
        mem_write_data = '0;
        if (state_q == S_CLEAR) begin
            mem_addr = ADDR_WIDTH'(cnt_q);
            mem_we   = 1'b1;
        end else if (state_q == S_SCAN) begin
            mem_addr = ADDR_WIDTH'(cnt_q);
        end else if (tok_v_q[WI]) begin
            mem_addr       = ADDR_WIDTH'(tok_a_q[WI]);
            mem_we         = 1'b1;
            mem_write_data = DATA_WIDTH'(hist_c_q[0]);
        end else if (tok_v_q[1]) begin
            mem_addr = ADDR_WIDTH'(tok_a_q[1]);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < TOP_K; i++) begin
            peak_angle[i*ANGLE_BITS +: ANGLE_BITS]   = pk_a_q[i][BW-1:RADIUS_BITS];
            peak_radius[i*RADIUS_BITS +: RADIUS_BITS] = pk_a_q[i][RADIUS_BITS-1:0];
            peak_count[i*COUNT_WIDTH +: COUNT_WIDTH]  = pk_c_q[i];
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        phase_d      = ~phase_q;
        cnt_d        = cnt_q;
        saturated_d  = saturated_q;
        peak_valid_d = peak_valid_q;
        tok_v_d      = tok_v_q;
        tok_a_d      = tok_a_q;
        hist_v_d     = hist_v_q;
        hist_a_d     = hist_a_q;
        hist_c_d     = hist_c_q;
        scan_v_d     = scan_v_q;
        scan_a_d     = scan_a_q;
        pk_c_d       = pk_c_q;
        pk_a_d       = pk_a_q;
        old_cnt      = rd_cnt;
        found        = 1'b0;
        idx          = 0;
        start        = P_NONE;
        cmd_new      = cmd_clear ? P_CLEAR : (cmd_scan ? P_SCAN : P_NONE);

        tok_v_d[0] = accept;
        tok_a_d[0] = {vote_angle, vote_radius};
        for (int unsigned k = 1; k <= WI; k++) begin
            tok_v_d[k] = tok_v_q[k-1];
            tok_a_d[k] = tok_a_q[k-1];
        end
        scan_v_d[0] = (state_q == S_SCAN);
        scan_a_d[0] = cnt_q;
        for (int unsigned k = 1; k < MEM_LAT; k++) begin
            scan_v_d[k] = scan_v_q[k-1];
            scan_a_d[k] = scan_a_q[k-1];
        end

        // Older history entries are visited first so the newest matching write wins.
        if (tok_v_q[RI]) begin
            for (int unsigned i = 0; i < HD; i++) begin
                if (hist_v_q[HD-1-i] && hist_a_q[HD-1-i] == tok_a_q[RI])
                    old_cnt = hist_c_q[HD-1-i];
            end
            for (int unsigned k = 1; k < HD; k++) begin
                hist_v_d[k] = hist_v_q[k-1];
                hist_a_d[k] = hist_a_q[k-1];
                hist_c_d[k] = hist_c_q[k-1];
            end
            hist_v_d[0] = 1'b1;
            hist_a_d[0] = tok_a_q[RI];
            if (old_cnt == CMAX) begin
                hist_c_d[0] = old_cnt;
                saturated_d = 1'b1;
            end else begin
                hist_c_d[0] = old_cnt + 1'b1;
            end
        end

        if (scan_v_q[MEM_LAT-1]) begin
            for (int unsigned i = 0; i < TOP_K; i++) begin
                if (!found && rd_cnt > pk_c_q[i]) begin
                    found = 1'b1;
                    idx   = i;
                end
            end
            if (found) begin
                for (int unsigned i = 0; i < TOP_K; i++) begin
                    if (i > idx) begin
                        pk_c_d[i] = pk_c_q[i-1];
                        pk_a_d[i] = pk_a_q[i-1];
                    end else if (i == idx) begin
                        pk_c_d[i] = rd_cnt;
                        pk_a_d[i] = scan_a_q[MEM_LAT-1];
                    end
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (pend_q == P_NONE && cmd_new != P_NONE) begin
                    if (early_busy) begin
                        state_d = S_DRAIN;
                        pend_d  = cmd_new;
                    end else begin
                        start = cmd_new;
                    end
                end
            end
            S_DRAIN: begin
                if (!early_busy) begin
                    state_d = S_IDLE;
                    start   = pend_q;
                    pend_d  = P_NONE;
                end
            end
            S_CLEAR: begin
                if (cnt_q == '1) state_d = S_DONE;
                else             cnt_d = cnt_q + 1'b1;
            end
            S_SCAN: begin
                if (cnt_q == '1) begin
                    state_d = S_SCAN_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SCAN_WAIT: begin
                if (cnt_q == BW'(MEM_LAT)) begin
                    state_d      = S_DONE;
                    peak_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (start == P_CLEAR) begin
            state_d      = S_CLEAR;
            cnt_d        = '0;
            saturated_d  = 1'b0;
            peak_valid_d = 1'b0;
            for (int unsigned k = 0; k < HD; k++) hist_v_d[k] = 1'b0;
        end else if (start == P_SCAN) begin
            state_d      = S_SCAN;
            cnt_d        = '0;
            peak_valid_d = 1'b0;
            for (int unsigned i = 0; i < TOP_K; i++) begin
                pk_c_d[i] = '0;
                pk_a_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pend_q       <= P_NONE;
            phase_q      <= 1'b1;
            cnt_q        <= '0;
            saturated_q  <= 1'b0;
            peak_valid_q <= 1'b0;
            for (int unsigned k = 0; k <= WI; k++) begin
                tok_v_q[k] <= 1'b0;
                tok_a_q[k] <= '0;
            end
            for (int unsigned k = 0; k < HD; k++) begin
                hist_v_q[k] <= 1'b0;
                hist_a_q[k] <= '0;
                hist_c_q[k] <= '0;
            end
            for (int unsigned k = 0; k < MEM_LAT; k++) begin
                scan_v_q[k] <= 1'b0;
                scan_a_q[k] <= '0;
            end
            for (int unsigned i = 0; i < TOP_K; i++) begin
                pk_c_q[i] <= '0;
                pk_a_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            saturated_q  <= saturated_d;
            peak_valid_q <= peak_valid_d;
            tok_v_q      <= tok_v_d;
            tok_a_q      <= tok_a_d;
            hist_v_q     <= hist_v_d;
            hist_a_q     <= hist_a_d;
            hist_c_q     <= hist_c_d;
            scan_v_q     <= scan_v_d;
            scan_a_q     <= scan_a_d;
            pk_c_q       <= pk_c_d;
            pk_a_q       <= pk_a_d;
        end
    end
endmodule

// File: tb/tb_hough_vote_accumulator.sv
// Scoreboard bench for hough_vote_accumulator: a bin-count reference model queues the
// expected memory writes and done-time results; a negedge monitor consumes them.
module tb_hough_vote_accumulator;
    localparam int AB = 2;
    localparam int RB = 3;
    localparam int CW = 3;
    localparam int ML = 2;
    localparam int K  = 4;
    localparam int AW = 8;
    localparam int DW = 12;
    localparam int BW = AB + RB;
    localparam int N  = 1 << BW;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, cmd_clear = 1'b0, cmd_scan = 1'b0, vote_valid = 1'b0;
    logic vote_ready, mem_we, busy, done, saturated, peak_valid;
    logic [AB-1:0] vote_angle = '0;
    logic [RB-1:0] vote_radius = '0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_write_data, mem_read_data;
    logic [K*AB-1:0] peak_angle;
    logic [K*RB-1:0] peak_radius;
    logic [K*CW-1:0] peak_count;

    hough_vote_accumulator #(
        .ANGLE_BITS(AB), .RADIUS_BITS(RB), .COUNT_WIDTH(CW), .MEM_LAT(ML),
        .TOP_K(K), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .reset(reset), .cmd_clear(cmd_clear), .cmd_scan(cmd_scan),
        .vote_valid(vote_valid), .vote_ready(vote_ready), .vote_angle(vote_angle),
        .vote_radius(vote_radius), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .busy(busy),
        .done(done), .saturated(saturated), .peak_valid(peak_valid), .peak_angle(peak_angle),
        .peak_radius(peak_radius), .peak_count(peak_count)
    );

    // Synchronous memory with ML-cycle read latency.
    logic [DW-1:0] mem [N];
    logic [DW-1:0] rdp [ML];
    initial for (int i = 0; i < N; i++) mem[i] = 'hFF;
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[BW-1:0]] <= mem_write_data;
        rdp[0] <= mem[mem_addr[BW-1:0]];
        for (int k = 1; k < ML; k++) rdp[k] <= rdp[k-1];
    end
    assign mem_read_data = rdp[ML-1];

    typedef struct packed {
        logic [BW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    typedef struct packed {
        logic          is_scan;
        logic          sat;
        logic [K*AB-1:0] ang;
        logic [K*RB-1:0] rad;
        logic [K*CW-1:0] cnt;
    } dn_t;

    wr_t wr_q[$];
    dn_t dn_q[$];
    dn_t last_scan;
    int  ref_cnt [N];
    bit  ref_sat;
    int  tests = 0;
    int  fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_vote(input int b);
        if (ref_cnt[b] == MAXC) ref_sat = 1'b1;
        else ref_cnt[b]++;
        wr_q.push_back('{addr: BW'(b), data: DW'(ref_cnt[b])});
    endtask

    task automatic model_clear();
        dn_t e;
        for (int b = 0; b < N; b++) begin
            wr_q.push_back('{addr: BW'(b), data: '0});
            ref_cnt[b] = 0;
        end
        ref_sat = 1'b0;
        e = '0;
        dn_q.push_back(e);
    endtask

    // Top-K by repeated selection of the largest remaining nonzero bin, lowest address on ties.
    task automatic model_scan();
        dn_t e;
        bit  taken [N];
        int  best;
        e = '0;
        e.is_scan = 1'b1;
        e.sat = ref_sat;
        for (int b = 0; b < N; b++) taken[b] = 1'b0;
        for (int s = 0; s < K; s++) begin
            best = -1;
            for (int b = 0; b < N; b++)
                if (!taken[b] && ref_cnt[b] > 0 && (best < 0 || ref_cnt[b] > ref_cnt[best])) best = b;
            if (best >= 0) begin
                taken[best] = 1'b1;
                e.ang[s*AB +: AB] = AB'(best / (1 << RB));
                e.rad[s*RB +: RB] = RB'(best % (1 << RB));
                e.cnt[s*CW +: CW] = CW'(ref_cnt[best]);
            end
        end
        last_scan = e;
        dn_q.push_back(e);
    endtask

    always @(negedge clk) begin
        wr_t w;
        dn_t d;
        if (mem_we) begin
            if (wr_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL write_unexpected: got addr %0d data %0d, expected no write", mem_addr, mem_write_data);
            end else begin
                w = wr_q.pop_front();
                check("write_addr_data", {mem_addr, mem_write_data}, {AW'(w.addr), w.data});
            end
        end
        if (done) begin
            if (dn_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL done_unexpected: got done=1, expected done=0");
            end else begin
                d = dn_q.pop_front();
                check("done_peak_valid", peak_valid, d.is_scan);
                check("done_saturated", saturated, d.sat);
                if (d.is_scan) begin
                    check("peak_angle", peak_angle, d.ang);
                    check("peak_radius", peak_radius, d.rad);
                    check("peak_count", peak_count, d.cnt);
                end
            end
        end
    end

    task automatic do_vote(input int a, input int r);
        bit ok;
        ok = 1'b0;
        vote_angle  = AB'(a);
        vote_radius = RB'(r);
        vote_valid  = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (vote_ready) begin
                model_vote(a * (1 << RB) + r);
                ok = 1'b1;
            end
        end
        if (!ok) check("vote_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        vote_valid = 1'b0;
    endtask

    task automatic issue_cmd(input bit clr, input bit scn);
        cmd_clear = clr;
        cmd_scan  = scn;
        if (clr) model_clear();
        else if (scn) model_scan();
        @(posedge clk);
        #1;
        cmd_clear = 1'b0;
        cmd_scan  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_cycles);
        int cyc;
        cyc = 1;
        while (!done && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done) check({name, "_timeout"}, 0, 1);
        else if (exp_cycles >= 0) check(name, cyc, exp_cycles);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while (busy && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (busy) check("idle_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv;
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_vote_ready", vote_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_write_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_saturated", saturated, 0);
        check("rst_peak_valid", peak_valid, 0);
        check("rst_peaks", {peak_angle, peak_radius, peak_count}, 0);

        issue_cmd(1, 0);
        wait_done("clear_done_cycle", N + 1);

        for (int i = 0; i < 3; i++) do_vote(1, 5);
        wait_idle();
        check("hazard_mem13", mem[13], 3);

        for (int i = 0; i < MAXC + 2; i++) do_vote(0, 0);
        wait_idle();
        check("saturated_set", saturated, ref_sat);
        issue_cmd(1, 0);
        wait_done("clear_after_sat", N + 1);
        check("saturated_cleared", saturated, ref_sat);

        for (int i = 0; i < 4; i++) do_vote(0, 1);
        for (int i = 0; i < 7; i++) do_vote(2, 0);
        for (int i = 0; i < 4; i++) do_vote(3, 7);
        for (int i = 0; i < 2; i++) do_vote(1, 2);
        do_vote(1, 3);
        wait_idle();
        issue_cmd(0, 1);
        wait_done("scan_done_cycle", N + ML + 2);
        repeat (5) @(posedge clk);
        #1;
        check("peak_stable_count", peak_count, last_scan.cnt);
        check("peak_stable_valid", peak_valid, 1);

        do_vote(3, 3);
        @(posedge clk);
        #1;
        issue_cmd(0, 1);
        check("drain_ready_low0", vote_ready, 0);
        @(posedge clk);
        #1;
        check("drain_ready_low1", vote_ready, 0);
        check("drain_busy", busy, 1);
        wait_done("scan_after_drain", -1);

        issue_cmd(1, 1);
        wait_done("clear_wins", N + 1);

        for (int round = 0; round < 3; round++) begin
            for (int v = 0; v < 40; v++) begin
                do_vote($urandom_range(0, 3), $urandom_range(0, 1));
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            issue_cmd(0, 1);
            wait_done("random_scan", -1);
            issue_cmd(1, 0);
            wait_done("random_clear", N + 1);
        end

        issue_cmd(1, 0);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        wr_q.delete();
        dn_q.delete();
        check("midrst_mem_we", mem_we, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_vote_ready", vote_ready, 0);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = vote_ready;
        end
        check("midrst_ready_back", seen, 1);
        repeat (40) @(posedge clk);
        #1;

        issue_cmd(1, 0);
        wait_done("recover_clear", N + 1);
        for (int v = 0; v < 12; v++) begin
            rv = $urandom_range(0, N - 1);
            do_vote(rv / (1 << RB), rv % (1 << RB));
        end
        issue_cmd(0, 1);
        wait_done("recover_scan", -1);

        repeat (10) @(posedge clk);
        #1;
        check("write_queue_empty", wr_q.size(), 0);
        check("done_queue_empty", dn_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hough_vote_accumulator.md
# hough_vote_accumulator

Parametrised Hough accumulator engine that sits between the per-pixel angle/radius calculator and the ZBT frame memory. It has three jobs: clearing the accumulator array, applying a stream of votes as saturating read-modify-write increments, and scanning the array to report the TOP_K highest bins. Votes arrive on a valid/ready handshake, and read-after-write hazards between in-flight votes are resolved internally. This block replaces the fixed 45-angle burst interface and the separate find-highest pass with a single block.

## Interface
- ANGLE_BITS, 6: angle bin index width.
- RADIUS_BITS, 9: radius bin index width.
- COUNT_WIDTH, 16: accumulator count width, 1..DATA_WIDTH.
- MEM_LAT, 2: cycles from read address driven to read data valid.
- TOP_K, 4: number of peaks reported, 1..8.
- ADDR_WIDTH, 19: memory address width, at least ANGLE_BITS+RADIUS_BITS.
- DATA_WIDTH, 36: memory data width.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- cmd_clear  in  1  pulse; zero all bins.
- cmd_scan  in  1  pulse; find the top-K bins.
- vote_valid  in  1  vote present.
- vote_ready  out  1  vote accepted on an edge where valid&ready.
- vote_angle  in  ANGLE_BITS  angle bin.
- vote_radius  in  RADIUS_BITS  radius bin, already offset to unsigned.
- mem_addr  out  ADDR_WIDTH  {zero pad, angle, radius}.
- mem_we  out  1  write enable.
- mem_write_data  out  DATA_WIDTH  {zeros, count}.
- mem_read_data  in  DATA_WIDTH  only the low COUNT_WIDTH bits are used.
- busy  out  1  high in any state other than IDLE, or while votes are in flight.
- done  out  1  one-cycle pulse at the end of a clear or scan.
- saturated  out  1  sticky; some increment hit the maximum count.
- peak_valid  out  1  peak outputs hold the result of the last completed scan.
- peak_angle  out  TOP_K*ANGLE_BITS  slot 0 in the LSBs, slot 0 is the highest.
- peak_radius  out  TOP_K*RADIUS_BITS  same slot order.
- peak_count  out  TOP_K*COUNT_WIDTH  same slot order.

## Operation
- N = 2^(ANGLE_BITS+RADIUS_BITS) bins. Bin address = angle*2^RADIUS_BITS + radius.
- States:
  - IDLE: votes accepted.
  - CLEAR: one zero write per cycle, addresses 0..N-1 ascending.
  - DRAIN: in-flight votes retire; a latched command is held pending.
  - SCAN: one read per cycle, addresses 0..N-1 ascending.
  - SCAN_WAIT: MEM_LAT+1 cycles for the final reads to return and be compared.
  - DONE: one cycle, done=1, then IDLE.
- Vote path:
  - Single memory port, slotted: even cycles are read slots, odd cycles are write slots.
  - vote_ready is high only in IDLE, on a read slot, with no command pending.
  - An accepted vote's read is driven in the next read slot. Its write (old+1, saturating at 2^COUNT_WIDTH-1) is driven in the first write slot after the data returns.
  - Hazard rule: the value incremented must reflect every previously accepted vote, even if that vote's write has not yet reached memory. Satisfy this by forwarding from a history of in-flight and recent writes, most recent match wins.
  - At saturation the count is held and saturated is set.
- Commands:
  - Accepted only in IDLE/DRAIN and only when no command is already pending. Otherwise ignored.
  - If votes are in flight, go to DRAIN, then execute the command.
  - cmd_clear and cmd_scan in the same cycle: clear wins and the scan is dropped.
  - cmd_clear clears saturated and peak_valid at its start.
  - cmd_scan clears peak_valid at its start, and zeroes all K slots.
- Scan compare:
  - A returned count c enters at the first slot i with c > count[i]. Slots i..K-2 shift down by one; the old slot K-1 is discarded.
  - Strict > keeps the lower address on ties. Zero counts never enter. Unfilled slots read angle 0, radius 0, count 0.
- Reset (any state): state=IDLE, pipeline flushed, pending command dropped, no write issued. Memory contents are undefined afterwards, so a clear is required.

## Timing
- Reset values: vote_ready=0 in the cycle after reset, mem_we=0, mem_addr=0, mem_write_data=0, busy=0, done=0, saturated=0, peak_valid=0, all peak fields 0.
- Vote throughput: 1 per 2 cycles. The write is driven no later than MEM_LAT+3 cycles after acceptance.
- Clear from IDLE: first write in the cycle after cmd_clear. done pulses in cycle N+1.
- Scan from IDLE: first read in the cycle after cmd_scan. peak_valid=1 and done pulses together in cycle N+MEM_LAT+2. Peak outputs are stable until the next scan, clear, or reset.
- DRAIN adds at most MEM_LAT+3 cycles.

## Test plan
- Clear: ANGLE_BITS=2, RADIUS_BITS=3, memory prefilled with 0xFF -> exactly 32 writes of 0 to addresses 0..31, ascending, and done in cycle 33.
- Hazard: after a clear, vote (1,5) three times at full rate -> address 13 holds 3, and the writes observed are 1,2,3.
- Saturation: COUNT_WIDTH=2, five votes to (0,0) -> bin holds 3 and saturated=1; a following cmd_clear -> saturated=0.
- Scan ordering: bins (0,1)=4, (2,0)=7, (3,7)=4, (1,2)=2, (1,3)=1, scan with TOP_K=4 -> slots (2,0,7), (0,1,4), (3,7,4), (1,2,2); slot 0 is listed first, and the tie keeps the lower address.
- Command during votes: cmd_scan issued two cycles after a vote -> vote_ready drops, the vote's write lands before the first scan read, and the scan reports the vote.
- Reset mid-clear at cycle 10 -> mem_we=0 the next cycle, no done pulse, busy=0, and vote_ready reasserts on the next read slot.
